// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared opcode encodings, multiplier FSM states and the
// opcode-legality helper for alu_pipe.
// Optional feature macro: ALU_PIPE_MUL_EN (makes OP_MUL a legal opcode).
package alu_pipe_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_GTU = 4'h2;
  localparam logic [3:0] OP_LTU = 4'h3;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRL = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_AND = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_GTS = 4'h9;
  localparam logic [3:0] OP_LTS = 4'hA;
  localparam logic [3:0] OP_SRA = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } mul_st_e;

  // Opcodes are dense from 0 upward, so legality is a single bound check.
  function automatic logic op_legal(input logic [3:0] op);
`ifdef ALU_PIPE_MUL_EN
    return op <= OP_MUL;
`else
    return op <= OP_SRA;
`endif
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst_n  clock / async active-low reset (aborts any multiply)
//   start       load operands (only honoured in IDLE)
//   a, b        multiplicand / multiplier
//   drain       output stage can take the product this cycle
//   busy        multiply in progress (FSM in MUL)
//   done        product valid and being handed off this cycle
//   product     low WIDTH bits of a*b
module alu_mul_iter
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             drain,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  mul_st_e          state, nxt;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  // Finishing waits on drain so a stalled output stage never loses a product.
  always_comb begin
    nxt  = state;
    done = 1'b0;
    case (state)
      ST_IDLE: if (start) nxt = ST_MUL;
      ST_MUL: if (cnt == '0 && drain) begin
        done = 1'b1;
        nxt  = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Only the low WIDTH product bits are kept, so the multiplicand can be
  // shifted within WIDTH bits without losing anything that matters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == ST_IDLE && start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
    end else if (state == ST_MUL && cnt != '0) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
    end
  end

  assign busy    = (state == ST_MUL);
  assign product = acc;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked, registered ALU with full flag set.
// Optional feature macro: ALU_PIPE_MUL_EN (iterative MUL, opcode 4'hC).
// Ports:
//   clk, rst_n            clock / async active-low reset
//   in_valid, in_ready    input channel; op1, op2, operator qualify it
//   out_valid, out_ready  output channel; result and flags qualify it
//   result                registered result
//   isZero, negative      derived from registered result
//   carry, overflow, err  registered flags (ADD/SUB carry/ovf, illegal op)
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       operator,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             isZero,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic             err
);

  logic             rdy_en, busy, out_free, in_fire, is_mul, mul_done;
  logic [WIDTH-1:0] mul_prod;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] sra_v, res_c;
  logic [SHW-1:0]   shamt;
  logic             shift_oor, c_c, v_c, e_c;

  // Holds in_ready low through reset and the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  assign out_free = !out_valid || out_ready;
  assign in_ready = rdy_en && !busy && out_free;
  assign in_fire  = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
  assign is_mul = (operator == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (in_fire && is_mul),
    .a       (op1),
    .b       (op2),
    .drain   (out_free),
    .busy    (busy),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign is_mul   = 1'b0;
  assign busy     = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  assign sum       = {1'b0, op1} + {1'b0, op2};
  assign diff      = {1'b0, op1} - {1'b0, op2};  // diff[WIDTH] is the borrow
  assign shamt     = op2[SHW-1:0];
  assign shift_oor = |op2[WIDTH-1:SHW];
  assign sra_v     = $signed(op1) >>> shamt;

  always_comb begin
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    e_c   = !op_legal(operator);
    case (operator)
      OP_ADD: begin
        res_c = sum[WIDTH-1:0];
        c_c   = sum[WIDTH];
        v_c   = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = diff[WIDTH-1:0];
        c_c   = diff[WIDTH];
        v_c   = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_GTU: res_c = {{(WIDTH-1){1'b0}}, op1 > op2};
      OP_LTU: res_c = {{(WIDTH-1){1'b0}}, op1 < op2};
      OP_SLL: res_c = shift_oor ? '0 : op1 << shamt;
      OP_SRL: res_c = shift_oor ? '0 : op1 >> shamt;
      OP_OR:  res_c = op1 | op2;
      OP_AND: res_c = op1 & op2;
      OP_XOR: res_c = op1 ^ op2;
      OP_GTS: res_c = {{(WIDTH-1){1'b0}}, $signed(op1) > $signed(op2)};
      OP_LTS: res_c = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
      OP_SRA: res_c = shift_oor ? {WIDTH{op1[WIDTH-1]}} : sra_v;
      default: res_c = '0;  // illegal ops (and MUL, which is muxed below)
    endcase
  end

  // in_fire and mul_done are exclusive: busy blocks acceptance while a
  // multiply is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
    end else if (in_fire && !is_mul) begin
      out_valid <= 1'b1;
      result    <= res_c;
      carry     <= c_c;
      overflow  <= v_c;
      err       <= e_c;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= mul_prod;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign isZero   = (result == '0);
  assign negative = result[WIDTH-1];

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized + directed bench for alu_pipe (WIDTH=32) with a
// behavioural reference model and an in-order scoreboard.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [31:0] op1 = '0, op2 = '0, result;
  logic [3:0]  operator = '0;
  logic        isZero, carry, overflow, negative, err;

  alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .operator(operator), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .isZero(isZero), .carry(carry),
    .overflow(overflow), .negative(negative), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op; logic [31:0] a, b;
    bit has_x; logic [31:0] xr; logic [4:0] xf;
  } txn_t;
  typedef struct {
    logic [31:0] r; logic [4:0] f; bit mul; int t;
  } exp_t;

  txn_t pend[$];
  exp_t sb[$];
  int   total = 0, bad = 0, cyc = 0, n_acc = 0, n_out = 0;
  bit   mul_watch = 0;
  int   mul_t0 = 0, rdy_viol = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: flags packed as {zero, carry, overflow, negative, err}.
  function automatic logic [36:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r; bit c, v, e; int sa, sb; longint s, ss;
    r = 0; c = 0; v = 0; e = 0; sa = a; sb = b;
    case (op)
      4'd0: begin
        s = longint'(a) + longint'(b); r = s[31:0]; c = s[32];
        ss = longint'(sa) + longint'(sb);
        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd1: begin
        r = a - b; c = (a < b);
        ss = longint'(sa) - longint'(sb);
        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd2:  r = (a > b) ? 1 : 0;
      4'd3:  r = (a < b) ? 1 : 0;
      4'd4:  r = (b >= 32) ? 0 : a << b;
      4'd5:  r = (b >= 32) ? 0 : a >> b;
      4'd6:  r = a | b;
      4'd7:  r = a & b;
      4'd8:  r = a ^ b;
      4'd9:  r = (sa > sb) ? 1 : 0;
      4'd10: r = (sa < sb) ? 1 : 0;
      4'd11: r = sa >>> ((b >= 32) ? 31 : b);
      4'd12: if (MUL_EN) r = a * b; else e = 1;
      default: e = 1;
    endcase
    return {r, (r == 0), c, v, r[31], e};
  endfunction

  task automatic add(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    txn_t t;
    t.op = op; t.a = a; t.b = b; t.has_x = 0; t.xr = 0; t.xf = 0;
    pend.push_back(t);
  endtask

  task automatic addx(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] xr, input logic [4:0] xf);
    txn_t t;
    t.op = op; t.a = a; t.b = b; t.has_x = 1; t.xr = xr; t.xf = xf;
    pend.push_back(t);
  endtask

  // One cycle: drive just after negedge, judge handshakes just before posedge.
  task automatic step(input bit ordy);
    exp_t e; txn_t t; logic [36:0] m;
    out_ready = ordy;
    if (pend.size() > 0) begin
      in_valid = 1'b1; op1 = pend[0].a; op2 = pend[0].b; operator = pend[0].op;
    end else in_valid = 1'b0;
    #1;
    if (out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = sb.pop_front();
        chk("result", result, e.r);
        chk("flags", {isZero, carry, overflow, negative, err}, e.f);
        if (e.mul) chk("mul_latency_ge33", (cyc - e.t) >= 33, 1);
      end
    end
    if (mul_watch && cyc > mul_t0 && cyc < mul_t0 + 33 && in_ready) rdy_viol++;
    if (in_valid && in_ready) begin
      n_acc++;
      t = pend.pop_front();
      m = model(t.op, t.a, t.b);
      e.r = t.has_x ? t.xr : m[36:5];
      e.f = t.has_x ? t.xf : m[4:0];
      e.mul = MUL_EN && (t.op == OP_MUL);
      e.t = cyc;
      if (e.mul) begin mul_watch = 1; mul_t0 = cyc; end
      sb.push_back(e);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int pct);
    int budget = 5000;
    while ((pend.size() > 0 || sb.size() > 0) && budget > 0) begin
      step($urandom_range(0, 99) < pct);
      budget--;
    end
    if (budget == 0) chk("drain_timeout", pend.size() + sb.size(), 0);
    repeat (3) step(1'b1);  // any leftover output shows up as spurious_out
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {isZero, carry, overflow, negative, err}, 5'b10000);
    pend.delete(); sb.delete(); mul_watch = 0;
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); cyc++;
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] sp [5];
    sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFF_FFFF;
    sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
    case ($urandom_range(0, 3))
      0: return sp[$urandom_range(0, 4)];
      1: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int a0, o0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_flags", {isZero, carry, overflow, negative, err}, 5'b10000);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("in_ready_after_reset", in_ready, 1);
    @(negedge clk);

    // Directed corner cases with spec-derived expectations.
    addx(OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'b11000);
    addx(OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 5'b00110);
    addx(OP_SUB, 32'h3, 32'h5, 32'hFFFF_FFFE, 5'b01010);
    addx(OP_LTS, 32'hFFFF_FFFF, 32'h1, 32'h1, 5'b00000);
    addx(OP_LTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'b10000);
    addx(OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 5'b00010);
    addx(OP_SRA, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 5'b00010);
    addx(OP_SLL, 32'h1, 32'd32, 32'h0, 5'b10000);
    addx(4'hF, 32'h1234, 32'h5678, 32'h0, 5'b10001);
    if (MUL_EN) addx(OP_MUL, 32'h1_0000, 32'h1_0001, 32'h0001_0000, 5'b00000);
    else        addx(OP_MUL, 32'h1_0000, 32'h1_0001, 32'h0, 5'b10001);
    drain(100);

    // Backpressure: three ADDs with out_ready held low.
    a0 = n_acc; o0 = n_out;
    add(OP_ADD, 32'd10, 32'd1); add(OP_ADD, 32'd20, 32'd2); add(OP_ADD, 32'd30, 32'd3);
    repeat (5) step(1'b0);
    chk("bp_accepted_one", n_acc - a0, 1);
    chk("bp_result_held", result, 32'd11);
    #1 chk("bp_in_ready_low", in_ready, 0);
    drain(100);
    chk("bp_three_outputs", n_out - o0, 3);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      logic [3:0] op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15))
                                                   : 4'($urandom_range(0, 11));
      add(op, rnd_val(), rnd_val());
    end
    drain(70);

    // Reset with an output pending, then mid-multiply.
    add(OP_ADD, 32'd5, 32'd6); add(OP_XOR, 32'hF0, 32'h0F);
    repeat (3) step(1'b0);
    do_reset();
    add(OP_MUL, 32'd7, 32'd9);
    repeat (10) step(1'b1);
    do_reset();
    repeat (40) step(1'b1);
    #1 chk("no_out_after_abort", out_valid, 0);
    addx(OP_ADD, 32'd2, 32'd3, 32'd5, 5'b00000);
    drain(100);

    chk("mul_in_ready_low", rdy_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: cycle=%0d", cyc);
    $fatal(1);
  end

endmodule
